// File: rtl/systolic_array_os.sv
// Output-stationary systolic matrix engine: OUT = requant(bias + A*W), one PE per output element.
// A columns and W rows enter unskewed; the skew and the valid tags are generated internally.
module systolic_array_os #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned K_MAX      = 16,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(K_MAX)
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          start_i,
    input  logic [$clog2(K_MAX+1)-1:0]    cfg_k_i,
    input  logic [$clog2(ACC_WIDTH)-1:0]  cfg_shift_i,
    input  logic                          cfg_relu_i,
    input  logic                          bias_valid_i,
    output logic                          bias_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0]    bias_col_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0]    a_col_i,
    input  logic [COLS*DATA_WIDTH-1:0]    w_row_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ROWS*DATA_WIDTH-1:0]    out_col_o,
    output logic [$clog2(COLS)-1:0]       out_idx_o,
    output logic                          out_last_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned KW       = $clog2(K_MAX + 1);
    localparam int unsigned SW       = $clog2(ACC_WIDTH);
    localparam int unsigned IW       = $clog2(COLS);
    localparam int unsigned DrainLen = ROWS + COLS - 1;
    localparam int unsigned CntMax   = (K_MAX > DrainLen) ? K_MAX : DrainLen;
    localparam int unsigned CW       = $clog2(CntMax + 1);

    localparam logic signed [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SatMin = ~SatMax;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BIAS    = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_OUT     = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          relu_q, relu_d;
    logic          done_q, done_d;

    logic in_fire;
    logic bias_we;

    assign in_fire = in_valid_i && (state_q == ST_COMPUTE);
    assign bias_we = bias_valid_i && (state_q == ST_BIAS);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        k_d     = k_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_BIAS;
                    cnt_d   = '0;
                    idx_d   = '0;
                    k_d     = (cfg_k_i > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k_i;
                    shift_d = cfg_shift_i;
                    relu_d  = cfg_relu_i;
                end
            end
            ST_BIAS: begin
                if (bias_valid_i) begin
                    if (cnt_q == CW'(COLS - 1)) begin
                        cnt_d   = '0;
                        state_d = (k_q == '0) ? ST_DRAIN : ST_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_COMPUTE: begin
                if (in_valid_i) begin
                    if (cnt_q + CW'(1) == CW'(k_q)) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Long enough for the last tagged beat to reach PE(ROWS-1, COLS-1).
                if (cnt_q == CW'(DrainLen - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    if (idx_q == IW'(COLS - 1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Input skew: row r of A delayed r cycles, column c of W delayed c cycles
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] a_sk [ROWS];
    logic [ROWS-1:0]       v_sk;
    logic [DATA_WIDTH-1:0] w_sk [COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_sk[r] = a_col_i[r*DATA_WIDTH +: DATA_WIDTH];
            assign v_sk[r] = in_fire;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] dly_q [r];
            logic [r-1:0]          vld_q;
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int i = 0; i < r; i++) begin
                        dly_q[i] <= '0;
                    end
                    vld_q <= '0;
                end else begin
                    dly_q[0] <= a_col_i[r*DATA_WIDTH +: DATA_WIDTH];
                    vld_q[0] <= in_fire;
                    for (int i = 1; i < r; i++) begin
                        dly_q[i] <= dly_q[i-1];
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end
            assign a_sk[r] = dly_q[r-1];
            assign v_sk[r] = vld_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_w_skew
        if (c == 0) begin : g_direct
            assign w_sk[c] = w_row_i[c*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] dly_q [c];
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int i = 0; i < c; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= w_row_i[c*DATA_WIDTH +: DATA_WIDTH];
                    for (int i = 1; i < c; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign w_sk[c] = dly_q[c-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid: A and its tag move right, W moves down, acc stays put
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]        a_pe   [ROWS][COLS-1];
    logic                         v_pe   [ROWS][COLS-1];
    logic [DATA_WIDTH-1:0]        w_pe   [ROWS-1][COLS];
    logic signed [ACC_WIDTH-1:0]  acc_pe [ROWS][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe_col
            logic [DATA_WIDTH-1:0]         a_in;
            logic [DATA_WIDTH-1:0]         w_in;
            logic                          v_in;
            logic                          bias_hit;
            logic signed [2*DATA_WIDTH-1:0] prod;
            logic [DATA_WIDTH-1:0]         bias_el;
            logic signed [ACC_WIDTH-1:0]   acc_q;

            if (c == 0) begin : g_a_edge
                assign a_in = a_sk[r];
                assign v_in = v_sk[r];
            end else begin : g_a_link
                assign a_in = a_pe[r][c-1];
                assign v_in = v_pe[r][c-1];
            end

            if (r == 0) begin : g_w_edge
                assign w_in = w_sk[c];
            end else begin : g_w_link
                assign w_in = w_pe[r-1][c];
            end

            if (c < COLS - 1) begin : g_a_fwd
                logic [DATA_WIDTH-1:0] a_q;
                logic                  v_q;
                always_ff @(posedge clk or negedge nrst) begin
                    if (!nrst) begin
                        a_q <= '0;
                        v_q <= 1'b0;
                    end else begin
                        a_q <= a_in;
                        v_q <= v_in;
                    end
                end
                assign a_pe[r][c] = a_q;
                assign v_pe[r][c] = v_q;
            end

            if (r < ROWS - 1) begin : g_w_fwd
                logic [DATA_WIDTH-1:0] w_q;
                always_ff @(posedge clk or negedge nrst) begin
                    if (!nrst) begin
                        w_q <= '0;
                    end else begin
                        w_q <= w_in;
                    end
                end
                assign w_pe[r][c] = w_q;
            end

            assign bias_el  = bias_col_i[r*DATA_WIDTH +: DATA_WIDTH];
            assign bias_hit = bias_we && (cnt_q == CW'(c));
            assign prod     = $signed(a_in) * $signed(w_in);

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    acc_q <= '0;
                end else if (bias_hit) begin
                    acc_q <= {{(ACC_WIDTH-DATA_WIDTH){bias_el[DATA_WIDTH-1]}}, bias_el};
                end else if (v_in) begin
                    acc_q <= acc_q + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
                end
            end
            assign acc_pe[r][c] = acc_q;
        end
    end

    // ------------------------------------------------------------------
    // Requantisation of the selected column: shift, ReLU, saturate
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] rq_acc;
    logic signed [ACC_WIDTH-1:0] rq_sh;
    logic [DATA_WIDTH-1:0]       rq_val;

    always_comb begin
        out_col_o = '0;
        rq_acc    = '0;
        rq_sh     = '0;
        rq_val    = '0;
        for (int i = 0; i < ROWS; i++) begin
            rq_acc = acc_pe[i][idx_q];
            rq_sh  = rq_acc >>> shift_q;
            if (relu_q && rq_sh[ACC_WIDTH-1]) begin
                rq_sh = '0;
            end
            if (rq_sh > SatMax) begin
                rq_val = SatMax[DATA_WIDTH-1:0];
            end else if (rq_sh < SatMin) begin
                rq_val = SatMin[DATA_WIDTH-1:0];
            end else begin
                rq_val = rq_sh[DATA_WIDTH-1:0];
            end
            if (state_q == ST_OUT) begin
                out_col_o[i*DATA_WIDTH +: DATA_WIDTH] = rq_val;
            end
        end
    end

    assign bias_ready_o = (state_q == ST_BIAS);
    assign in_ready_o   = (state_q == ST_COMPUTE);
    assign out_valid_o  = (state_q == ST_OUT);
    assign out_idx_o    = idx_q;
    assign out_last_o   = (state_q == ST_OUT) && (idx_q == IW'(COLS - 1));
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;

endmodule

// File: doc/systolic_array_os.md
# systolic_array_os

Parametrised output-stationary systolic matrix engine computing OUT = requant(bias + A·W) for A (ROWS×K) and W (K×COLS), with K configurable per job up to K_MAX. Inputs are skewed internally, so producers stream unskewed columns of A and rows of W. The engine adds a per-element bias, applies a runtime arithmetic right shift, optional ReLU and signed saturation. Results stream out one column per valid/ready beat. It sits between the layer-input/weight buffers and the activation writeback path.

## Interface
- DATA_WIDTH, 8, signed two's-complement width of A, W, bias and output elements
- ROWS, 8, array rows (m)
- COLS, 8, array columns (n)
- K_MAX, 16, maximum inner dimension (l)
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K_MAX) (=20), signed accumulator width
- clk  in  1  single clock, all logic on posedge
- nrst  in  1  asynchronous, active-low reset
- start_i  in  1  job start, sampled only in IDLE
- cfg_k_i  in  $clog2(K_MAX+1)  inner dimension, latched at start; values >K_MAX clamp to K_MAX
- cfg_shift_i  in  $clog2(ACC_WIDTH)  right-shift amount, latched at start
- cfg_relu_i  in  1  ReLU enable, latched at start
- bias_valid_i / bias_ready_o  in/out  1  bias beat handshake
- bias_col_i  in  ROWS×DATA_WIDTH  bias for column c (beat c), element r → row r
- in_valid_i / in_ready_o  in/out  1  compute beat handshake
- a_col_i  in  ROWS×DATA_WIDTH  column k of A
- w_row_i  in  COLS×DATA_WIDTH  row k of W
- out_valid_o / out_ready_i  out/in  1  result beat handshake
- out_col_o  out  ROWS×DATA_WIDTH  result column out_idx_o
- out_idx_o  out  $clog2(COLS)  current output column
- out_last_o  out  1  high with beat of column COLS-1
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse after final output handshake

## Operation
- FSM: IDLE → BIAS (on start_i) → COMPUTE → DRAIN → OUT → IDLE.
- BIAS: bias_ready_o=1; beat c (c=0..COLS-1) writes sign-extended bias_col_i[r] into acc[r][c]; after beat COLS-1 → COMPUTE (or DRAIN directly if cfg_k=0).
- COMPUTE: in_ready_o=1; each accepted beat pushes a_col_i and w_row_i into skew chains with a valid tag. Row r of A delayed r cycles; column c of W delayed c cycles. Data and tag propagate right (A) and down (W) one PE per cycle. PE(r,c) does acc += a*w (signed, full product, wrap modulo 2^ACC_WIDTH) only when its tag is set. Bubbles (in_valid_i low) are legal and do not affect results. After cfg_k accepted beats → DRAIN.
- DRAIN: exactly ROWS+COLS-1 cycles, no inputs accepted, pipeline empties, then → OUT.
- OUT: out_valid_o=1; column index starts at 0 and advances on out_valid_o&&out_ready_i; out_col_o[r] = sat(relu(acc[r][idx] >>> cfg_shift)). Shift is arithmetic (floor). ReLU maps negatives to 0 when enabled. Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Handshake on idx COLS-1 → IDLE and done_o pulses.
- Accumulators hold their values after the job until the next BIAS overwrites them.
- start_i outside IDLE is ignored. bias/in valids outside their states are ignored (ready low).
- Reset: all state, accumulators, skew registers and tags cleared. State → IDLE. All outputs 0 (ready/valid/busy/done/last/idx/col all 0). Reset mid-job aborts with no partial output.

## Timing
- start_i high in IDLE at cycle t → BIAS at t+1. bias_ready_o high from t+1.
- BIAS and COMPUTE accept one beat per cycle at most. Minimum job is COLS + cfg_k + (ROWS+COLS-1) + COLS cycles plus 1 start cycle.
- Last compute beat accepted at T → DRAIN from T+1 to T+ROWS+COLS-1 → out_valid_o high at T+ROWS+COLS.
- out_col_o, out_idx_o and out_last_o are combinational from the acc array and the registered index, and stay stable while out_valid_o && !out_ready_i.
- done_o is high in the cycle after the final handshake, with busy_o=0 in that same cycle. A new start_i is accepted in that cycle.

## Test plan
- Identity: cfg_k=8, A=I, W[k][c]=k*8+c, bias 0, shift 0, relu off → column c outputs W[r][c], out_last on beat 7, done pulse.
- Scaling: all A=16, W=8, cfg_k=8, bias 0, shift 7 → every element 8. Repeat with bias=-24 → 7 (floor of 1000/128).
- Saturation/ReLU: A=-128, W=127, cfg_k=16, shift 0 → all -128; relu on → all 0. A=W=-128, cfg_k=16 → all 127.
- Bubbles/backpressure: random in_valid_i gaps and out_ready_i toggling → results bit-identical to gap-free run; out_col_o stable during stalls; exactly 8 output beats.
- Edge config: cfg_k=0 with bias=r*4+c, shift 2 → out[r][c]=r+(c>>2). cfg_k=31 behaves exactly as cfg_k=16. start_i pulsed during COMPUTE is ignored.
- Reset: assert nrst low mid-COMPUTE → all outputs 0 immediately. After release, a full identity job passes.
